square_range_gen: RTL and testbench
===================================

Name: square_range_gen

Overview:
- Inverse partner of Square_root_floor: takes a root r and returns the range of inputs whose floor square root is r.
- Outputs lo = r*r and hi = (r+1)^2 - 1.
- Used as a reference generator and sweep-bound source for checking the square-root block.
- Iterative shift-add squarer with a start/busy/done handshake; one clock domain.

Parameters:
- ROOT_W, 5, width of the root input; matches the Square_root_floor sqrt width.
- NUM_W, 2*ROOT_W (10), width of lo/hi; matches the Square_root_floor num width. Derived; do not override independently.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- root  input  ROOT_W  root r; captured on the edge that accepts start.
- busy  output  1  high while a computation is in flight.
- done  output  1  single-cycle pulse; lo/hi valid.
- lo  output  NUM_W  r*r.
- hi  output  NUM_W  (r+1)^2 - 1, equal to r*r + 2*r.

Behaviour:
- Reset:
  - rst high forces IDLE immediately, regardless of clk.
  - busy=0, done=0, lo=0, hi=0.
  - Internal accumulator, multiplicand, bit counter and latched root all cleared.
- States: IDLE, MUL, ADD.
- IDLE:
  - start=1 at a rising edge latches root into r_q, clears acc, sets cnt=0 and moves to MUL.
  - busy rises at that same edge.
  - start=0 keeps the block in IDLE.
- MUL, one edge per root bit, ROOT_W edges in total:
  - If r_q[cnt] is set, acc <= acc + (r_q << cnt). acc is NUM_W bits wide; it cannot overflow for NUM_W = 2*ROOT_W.
  - cnt increments each edge.
  - After the edge with cnt = ROOT_W-1, move to ADD.
- ADD, one edge:
  - lo <= acc.
  - hi <= acc + (r_q << 1), computed in NUM_W bits. Max value is 961 + 62 = 1023, so no overflow.
  - done <= 1 and busy <= 0 at this edge; return to IDLE.
- done:
  - High for exactly one cycle, cleared at the following edge.
  - lo/hi hold their values until the next ADD edge or reset.
- Latency:
  - The edge that accepts start is edge 0. done and the new lo/hi appear after edge ROOT_W+1 (edge 6 at default).
  - Start-to-start throughput is ROOT_W+2 cycles.
- start while busy (MUL/ADD): ignored. No queuing, no effect on the in-flight result.
- Changes on root after acceptance: ignored; only r_q is used.
- start high in the cycle where done=1: the state is IDLE, so it is accepted. Back-to-back operation is allowed, with no idle gap required.
- start held high continuously: a new operation starts every ROOT_W+2 cycles.
- Reset mid-operation: aborts the operation; no done pulse; outputs cleared to 0.
- Boundary values:
  - r=0 gives lo=0, hi=0.
  - r=2^ROOT_W-1 gives lo=961, hi=1023 (full NUM_W range).
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset 20 ns, then start with root=3 -> busy high from accept edge; done pulses 6 edges later; lo=9, hi=15; busy=0 while done=1.
- root=0 -> lo=0, hi=0. root=31 -> lo=961, hi=1023. Check no wrap and the exact single-cycle done pulse.
- Start root=5, then 2 cycles later pulse start with root=7 while busy -> one done only; lo=25, hi=35. Then a new start accepted in the done cycle with root=7 -> lo=49, hi=63 after 6 more edges.
- Start root=12, assert rst asynchronously (mid-cycle) at cycle 3 -> busy/done/lo/hi = 0 immediately; after release, root=12 completes with lo=144, hi=168.
- Exhaustive cross-check: for r = 0..31 run the block, then drive Square_root_floor num over [lo, hi] -> sqrt == r for every num. The union of all ranges covers 0..1023 exactly once.

Source files
------------

// File: rtl/square_range_gen_if.sv
// Handshake and result bundle for square_range_gen.
// The master side issues start/root requests; the slave side (the generator)
// returns busy/done and the lo/hi range of the requested root.
interface square_range_gen_if #(
    parameter int ROOT_W = 5,
    parameter int NUM_W  = 2 * ROOT_W
);
    logic              start;
    logic [ROOT_W-1:0] root;
    logic              busy;
    logic              done;
    logic [NUM_W-1:0]  lo;
    logic [NUM_W-1:0]  hi;

    modport master (
        output start,
        output root,
        input  busy,
        input  done,
        input  lo,
        input  hi
    );

    modport slave (
        input  start,
        input  root,
        output busy,
        output done,
        output lo,
        output hi
    );
endinterface

// File: rtl/square_range_gen.sv
// square_range_gen: given a root r, returns lo = r*r and hi = (r+1)^2 - 1,
// i.e. the range of inputs whose floor square root is r.
// r*r is built by an iterative shift-add squarer (one root bit per cycle),
// then hi is formed as r*r + 2*r in a final add cycle.
module square_range_gen #(
    parameter int ROOT_W = 5,
    parameter int NUM_W  = 2 * ROOT_W
) (
    input  logic               clk,
    input  logic               rst,
    square_range_gen_if.slave  bus
);
    localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROOT_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ROOT_W-1:0] r_q,     r_d;
    logic [NUM_W-1:0]  acc_q,   acc_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic [NUM_W-1:0]  lo_q,    lo_d;
    logic [NUM_W-1:0]  hi_q,    hi_d;

    // Latched root zero-extended to the accumulator width for shifting.
    logic [NUM_W-1:0]  r_ext_s;
    assign r_ext_s = {{(NUM_W-ROOT_W){1'b0}}, r_q};

    // Next-state logic: accept in IDLE, one partial product per MUL cycle, final range in ADD.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lo_d    = lo_q;
        hi_d    = hi_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    r_d     = bus.root;
                    acc_d   = {NUM_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                // Partial product r * (bit cnt of r) = r << cnt when that bit is set.
                if (r_q[cnt_q]) begin
                    acc_d = acc_q + (r_ext_s << cnt_q);
                end else begin
                    acc_d = acc_q;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_ADD: begin
                // (r+1)^2 - 1 = r*r + 2*r; fits in NUM_W bits for every r.
                lo_d    = acc_q;
                hi_d    = acc_q + (r_ext_s << 1);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; async reset clears everything and aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= {ROOT_W{1'b0}};
            acc_q   <= {NUM_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lo_q    <= {NUM_W{1'b0}};
            hi_q    <= {NUM_W{1'b0}};
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.lo   = lo_q;
    assign bus.hi   = hi_q;
endmodule

// File: tb/tb_square_range_gen.sv
// Bench for square_range_gen: directed vectors with literal expectations,
// a cycle-level behavioural model compared every cycle, and a range cross-check.
module tb_square_range_gen;
    localparam int ROOT_W = 5;
    localparam int NUM_W  = 2 * ROOT_W;
    localparam int LAT    = ROOT_W + 1;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    time  t_acc;
    bit   cmp_en = 1'b0;
    int   cov [0:1023];

    square_range_gen_if #(.ROOT_W(ROOT_W), .NUM_W(NUM_W)) bus ();

    square_range_gen #(.ROOT_W(ROOT_W), .NUM_W(NUM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted request produces done and r*r / (r+1)^2-1
    // exactly LAT edges later; requests made while a result is pending are dropped.
    int m_left;
    int m_r;
    bit m_busy, m_done;
    int m_lo, m_hi;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0; m_r <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_lo <= 0; m_hi <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                    m_lo   <= m_r * m_r;
                    m_hi   <= (m_r + 1) * (m_r + 1) - 1;
                end
            end else if (bus.start) begin
                m_r    <= int'(bus.root);
                m_left <= LAT;
                m_busy <= 1'b1;
            end
        end
    end

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("model_busy", bus.busy, m_busy);
            chk("model_done", bus.done, m_done);
            chk("model_lo",   bus.lo,   m_lo);
            chk("model_hi",   bus.hi,   m_hi);
        end
    end

    function automatic int isqrt(input int n);
        int s = 0;
        while ((s + 1) * (s + 1) <= n) s++;
        return s;
    endfunction

    // Request r; returns just after the accept edge with busy checked.
    task automatic start_op(input int r);
        @(negedge clk);
        bus.start = 1'b1;
        bus.root  = r[ROOT_W-1:0];
        @(posedge clk);
        t_acc = $time;
        #1;
        chk("busy_rise", bus.busy, 1);
        chk("no_done_at_accept", bus.done, 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.root  = ~r[ROOT_W-1:0];
    endtask

    // Wait (bounded) for done, checking latency and values; ends 1 time unit after the done edge.
    task automatic wait_done(input string tag, input int elo, input int ehi);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_latency"}, int'(($time - 1 - t_acc) / 10), LAT);
            chk({tag, "_lo"}, bus.lo, elo);
            chk({tag, "_hi"}, bus.hi, ehi);
            chk({tag, "_busy_low"}, bus.busy, 0);
        end
    endtask

    task automatic run_check(input string tag, input int r, input int elo, input int ehi);
        start_op(r);
        wait_done(tag, elo, ehi);
        @(posedge clk);
        #1;
        chk({tag, "_done_1cyc"}, bus.done, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.root  = '0;
        rst = 1'b1;
        #20;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_hi", bus.hi, 0);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        run_check("r3", 3, 9, 15);
        run_check("r0", 0, 0, 0);
        run_check("r31", 31, 961, 1023);

        // Start while busy is ignored; then back-to-back start in the done cycle.
        start_op(5);
        @(negedge clk);
        bus.start = 1'b1; bus.root = 5'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("r5", 25, 35);
        bus.start = 1'b1;
        bus.root  = 5'd7;
        @(posedge clk);
        t_acc = $time;
        #1;
        chk("b2b_busy", bus.busy, 1);
        chk("b2b_done_low", bus.done, 0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("r7", 49, 63);

        // Asynchronous reset mid-operation.
        start_op(12);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_lo", bus.lo, 0);
        chk("arst_hi", bus.hi, 0);
        @(negedge clk);
        rst = 1'b0;
        run_check("r12", 12, 144, 168);

        // Start held high: a new operation every LAT+1 cycles (model checks each cycle).
        @(negedge clk);
        bus.start = 1'b1;
        bus.root  = 5'd2;
        repeat (3 * (LAT + 1)) @(negedge clk);
        bus.start = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // Every root: its [lo,hi] must map back to r under floor sqrt, covering 0..1023 once.
        for (int n = 0; n < 1024; n++) cov[n] = 0;
        chk("isqrt_pin_15", isqrt(15), 3);
        chk("isqrt_pin_16", isqrt(16), 4);
        for (int r = 0; r < 32; r++) begin
            int bad;
            start_op(r);
            wait_done("sweep", r * r, (r + 1) * (r + 1) - 1);
            bad = 0;
            for (int n = int'(bus.lo); n <= int'(bus.hi); n++) begin
                if (isqrt(n) != r) bad++;
                cov[n]++;
            end
            chk("sweep_range", bad, 0);
        end
        begin
            int holes = 0;
            for (int n = 0; n < 1024; n++) if (cov[n] != 1) holes++;
            chk("sweep_cover", holes, 0);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
